// File: rtl/cache_line_axi_ctrl.sv
// rtl/cache_line_axi_ctrl.sv - cache-line writeback/refill sequencer in front of the AXI4 master
module cache_line_axi_ctrl #(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     i_wb_req,
  input  logic                     i_fill_req,
  input  logic [ADDR_W-1:0]        i_wb_addr,
  input  logic [ADDR_W-1:0]        i_fill_addr,
  input  logic [LINE_WORDS*64-1:0] i_wb_line,
  output logic [LINE_WORDS*64-1:0] o_fill_line,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_write_req,
  output logic                     o_read_req,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [63:0]              o_write_data,
  output logic [7:0]               o_axi_len,
  output logic [2:0]               o_axi_size,
  output logic [1:0]               o_axi_burst,
  output logic [7:0]               o_axi_strb,
  input  logic [63:0]              i_read_data,
  input  logic                     i_axi_done,
  input  logic                     i_axi_handshake
);

  localparam int CW  = $clog2(LINE_WORDS);
  localparam int OFF = $clog2(LINE_WORDS * 8);
  localparam logic [CW-1:0]     LAST       = CW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));

  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_WB_DATA, S_FILL_REQ, S_FILL_DATA, S_DONE
  } state_t;

  state_t                        state;
  logic [CW-1:0]                 cnt;
  logic                          pend_fill;
  logic                          fill_full;
  logic [ADDR_W-1:0]             fill_addr_q;
  logic [LINE_WORDS-1:0][63:0]   line_q;
  logic [LINE_WORDS-1:0][63:0]   fill_q;

  assign o_fill_line  = fill_q;
  assign o_write_data = line_q[cnt];
  assign o_axi_len    = 8'(LINE_WORDS - 1);
  assign o_axi_size   = 3'b011;
  assign o_axi_burst  = 2'b01;
  assign o_axi_strb   = 8'hFF;

  always_ff @(posedge clk) begin
    if (arst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pend_fill   <= 1'b0;
      fill_full   <= 1'b0;
      fill_addr_q <= '0;
      line_q      <= '0;
      fill_q      <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_write_req <= 1'b0;
      o_read_req  <= 1'b0;
      o_addr      <= '0;
    end else begin
      o_write_req <= 1'b0;
      o_read_req  <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_wb_req) begin
            line_q      <= i_wb_line;
            fill_addr_q <= i_fill_addr;
            pend_fill   <= i_fill_req;
            o_addr      <= i_wb_addr & ALIGN_MASK;
            o_write_req <= 1'b1;
            o_busy      <= 1'b1;
            state       <= S_WB_REQ;
          end else if (i_fill_req) begin
            fill_addr_q <= i_fill_addr;
            pend_fill   <= 1'b0;
            o_addr      <= i_fill_addr & ALIGN_MASK;
            o_read_req  <= 1'b1;
            o_busy      <= 1'b1;
            state       <= S_FILL_REQ;
          end
        end
        S_WB_REQ: begin
          cnt   <= '0;
          state <= S_WB_DATA;
        end
        S_WB_DATA: begin
          if (i_axi_handshake && cnt != LAST) cnt <= cnt + 1'b1;
          if (i_axi_done) begin
            if (pend_fill) begin
              o_addr     <= fill_addr_q & ALIGN_MASK;
              o_read_req <= 1'b1;
              state      <= S_FILL_REQ;
            end else begin
              o_done <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_FILL_REQ: begin
          cnt       <= '0;
          fill_full <= 1'b0;
          state     <= S_FILL_DATA;
        end
        S_FILL_DATA: begin
          // fill_full stops a beat past the end from overwriting the last word
          if (i_axi_handshake && !fill_full) begin
            fill_q[cnt] <= i_read_data;
            if (cnt == LAST) fill_full <= 1'b1;
            else             cnt       <= cnt + 1'b1;
          end
          if (i_axi_done) begin
            o_done <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_axi_ctrl.sv
// tb/tb_cache_line_axi_ctrl.sv - directed bench for cache_line_axi_ctrl
module tb_cache_line_axi_ctrl;

  localparam int LW = 8;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            arst;
  logic            i_wb_req, i_fill_req;
  logic [AW-1:0]   i_wb_addr, i_fill_addr;
  logic [LW*64-1:0] i_wb_line;
  logic [LW*64-1:0] o_fill_line;
  logic            o_busy, o_done, o_write_req, o_read_req;
  logic [AW-1:0]   o_addr;
  logic [63:0]     o_write_data;
  logic [7:0]      o_axi_len;
  logic [2:0]      o_axi_size;
  logic [1:0]      o_axi_burst;
  logic [7:0]      o_axi_strb;
  logic [63:0]     i_read_data;
  logic            i_axi_done, i_axi_handshake;

  int passed = 0;
  int total  = 0;
  int wr_pulses = 0, rd_pulses = 0, done_pulses = 0, both_high = 0;

  always #5 clk = ~clk;

  cache_line_axi_ctrl #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .arst(arst),
    .i_wb_req(i_wb_req), .i_fill_req(i_fill_req),
    .i_wb_addr(i_wb_addr), .i_fill_addr(i_fill_addr), .i_wb_line(i_wb_line),
    .o_fill_line(o_fill_line), .o_busy(o_busy), .o_done(o_done),
    .o_write_req(o_write_req), .o_read_req(o_read_req), .o_addr(o_addr),
    .o_write_data(o_write_data), .o_axi_len(o_axi_len), .o_axi_size(o_axi_size),
    .o_axi_burst(o_axi_burst), .o_axi_strb(o_axi_strb),
    .i_read_data(i_read_data), .i_axi_done(i_axi_done), .i_axi_handshake(i_axi_handshake)
  );

  always @(posedge clk) begin
    wr_pulses   <= wr_pulses + int'(o_write_req);
    rd_pulses   <= rd_pulses + int'(o_read_req);
    done_pulses <= done_pulses + int'(o_done);
    both_high   <= both_high + int'(o_write_req && o_read_req);
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [LW*64-1:0] mk_line(input logic [63:0] base);
    logic [LW*64-1:0] l;
    for (int k = 0; k < LW; k++) l[k*64 +: 64] = base + 64'(k);
    return l;
  endfunction

  // fill from IDLE; with_last_done puts i_axi_done on the last beat
  task automatic run_fill(input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                          input logic [63:0] base, input bit with_last_done);
    i_fill_req = 1'b1; i_fill_addr = addr;
    tick();
    chk("fill_read_req", o_read_req, 1'b1);
    chk("fill_addr", o_addr, exp_addr);
    chk("fill_busy", o_busy, 1'b1);
    i_fill_req = 1'b0;
    tick();
    chk("fill_req_one_cycle", o_read_req, 1'b0);
    for (int k = 0; k < LW; k++) begin
      i_axi_handshake = 1'b1; i_read_data = base + 64'(k);
      i_axi_done = with_last_done && (k == LW - 1);
      tick();
    end
    i_axi_handshake = 1'b0;
    if (!with_last_done) begin
      i_axi_done = 1'b1;
      tick();
    end
    i_axi_done = 1'b0;
    chk("fill_done_pulse", o_done, 1'b1);
    chk("fill_busy_in_done", o_busy, 1'b1);
    tick();
    chk("fill_done_clear", o_done, 1'b0);
    chk("fill_busy_clear", o_busy, 1'b0);
    chk("fill_line", o_fill_line, mk_line(base));
  endtask

  int wr0, rd0, dn0;

  initial begin
    arst = 1'b1; i_wb_req = 0; i_fill_req = 0; i_wb_addr = '0; i_fill_addr = '0;
    i_wb_line = '0; i_read_data = '0; i_axi_done = 0; i_axi_handshake = 0;
    tick(); tick();
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_wr", o_write_req, 1'b0);
    chk("rst_rd", o_read_req, 1'b0);
    chk("rst_addr", o_addr, '0);
    chk("rst_line", o_fill_line, '0);
    chk("axi_len", o_axi_len, 8'd7);
    chk("axi_size", o_axi_size, 3'b011);
    chk("axi_burst", o_axi_burst, 2'b01);
    chk("axi_strb", o_axi_strb, 8'hFF);
    arst = 1'b0;
    tick();

    // fill only
    rd0 = rd_pulses; dn0 = done_pulses;
    run_fill(32'h1000_0024, 32'h1000_0000, 64'h100, 1'b0);
    tick();
    chk("fill_rd_count", rd_pulses - rd0, 1);
    chk("fill_done_count", done_pulses - dn0, 1);

    // writeback only with random gaps
    wr0 = wr_pulses; dn0 = done_pulses;
    i_wb_req = 1'b1; i_wb_addr = 32'h2000_0040; i_wb_line = mk_line(64'hA0);
    tick();
    chk("wb_write_req", o_write_req, 1'b1);
    chk("wb_addr", o_addr, 32'h2000_0040);
    i_wb_req = 1'b0;
    tick();
    chk("wb_req_one_cycle", o_write_req, 1'b0);
    for (int k = 0; k < LW; k++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("wb_data_hold", o_write_data, 64'hA0 + 64'(k));
      end
      chk("wb_data", o_write_data, 64'hA0 + 64'(k));
      i_axi_handshake = 1'b1;
      tick();
      i_axi_handshake = 1'b0;
    end
    chk("wb_data_sat", o_write_data, 64'hA7);
    chk("wb_no_done_early", o_done, 1'b0);
    i_axi_done = 1'b1;
    tick();
    i_axi_done = 1'b0;
    chk("wb_done", o_done, 1'b1);
    chk("wb_keeps_fill_line", o_fill_line, mk_line(64'h100));
    tick();
    chk("wb_idle", o_busy, 1'b0);
    tick();
    chk("wb_wr_count", wr_pulses - wr0, 1);
    chk("wb_done_count", done_pulses - dn0, 1);

    // combined evict-then-fill, with a 9th read beat that must be dropped
    wr0 = wr_pulses; rd0 = rd_pulses; dn0 = done_pulses;
    i_wb_req = 1'b1; i_fill_req = 1'b1; i_wb_addr = 32'h3000_0010;
    i_fill_addr = 32'h4000_0088; i_wb_line = mk_line(64'hB0);
    tick();
    chk("cmb_write_req", o_write_req, 1'b1);
    chk("cmb_read_req_low", o_read_req, 1'b0);
    chk("cmb_wb_addr", o_addr, 32'h3000_0000);
    i_wb_req = 1'b0; i_fill_req = 1'b0;
    tick();
    for (int k = 0; k < LW; k++) begin
      chk("cmb_wb_data", o_write_data, 64'hB0 + 64'(k));
      i_axi_handshake = 1'b1;
      tick();
    end
    i_axi_handshake = 1'b0; i_axi_done = 1'b1;
    tick();
    i_axi_done = 1'b0;
    chk("cmb_read_req", o_read_req, 1'b1);
    chk("cmb_fill_addr", o_addr, 32'h4000_0080);
    chk("cmb_no_mid_done", o_done, 1'b0);
    chk("cmb_busy", o_busy, 1'b1);
    tick();
    for (int k = 0; k < LW + 1; k++) begin
      i_axi_handshake = 1'b1;
      i_read_data = (k < LW) ? 64'h200 + 64'(k) : 64'hDEAD;
      tick();
    end
    i_axi_handshake = 1'b0; i_axi_done = 1'b1;
    tick();
    i_axi_done = 1'b0;
    chk("cmb_done", o_done, 1'b1);
    chk("cmb_line_9th_dropped", o_fill_line, mk_line(64'h200));
    tick(); tick();
    chk("cmb_wr_count", wr_pulses - wr0, 1);
    chk("cmb_rd_count", rd_pulses - rd0, 1);
    chk("cmb_done_count", done_pulses - dn0, 1);

    // last beat arrives with done; line holds until the first new beat
    i_fill_req = 1'b1; i_fill_addr = 32'h5000_0000;
    tick();
    i_fill_req = 1'b0;
    tick();
    chk("hold_line", o_fill_line, mk_line(64'h200));
    for (int k = 0; k < LW; k++) begin
      i_axi_handshake = 1'b1; i_read_data = 64'h300 + 64'(k);
      i_axi_done = (k == LW - 1);
      tick();
    end
    i_axi_handshake = 1'b0; i_axi_done = 1'b0;
    chk("same_cycle_done", o_done, 1'b1);
    chk("same_cycle_line", o_fill_line, mk_line(64'h300));
    tick();

    // reset during WB_DATA after 3 beats
    i_wb_req = 1'b1; i_wb_addr = 32'h6000_0000; i_wb_line = mk_line(64'hC0);
    tick();
    i_wb_req = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      i_axi_handshake = 1'b1;
      tick();
    end
    i_axi_handshake = 1'b0;
    chk("pre_rst_data", o_write_data, 64'hC3);
    dn0 = done_pulses;
    arst = 1'b1;
    tick();
    arst = 1'b0;
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_done", o_done, 1'b0);
    chk("mid_rst_wr", o_write_req, 1'b0);
    chk("mid_rst_rd", o_read_req, 1'b0);
    chk("mid_rst_addr", o_addr, '0);
    chk("mid_rst_line", o_fill_line, '0);
    i_axi_done = 1'b1;
    tick();
    i_axi_done = 1'b0;
    chk("idle_ignores_done", o_done, 1'b0);
    chk("idle_after_rst", o_busy, 1'b0);
    tick();
    chk("rst_no_done_pulse", done_pulses - dn0, 0);
    run_fill(32'h7000_003F, 32'h7000_0000, 64'h400, 1'b0);
    tick();

    // requests while busy are ignored
    rd0 = rd_pulses; wr0 = wr_pulses;
    i_fill_req = 1'b1; i_fill_addr = 32'h8000_0000;
    tick();
    i_fill_req = 1'b0;
    tick();
    i_fill_req = 1'b1; i_wb_req = 1'b1; i_fill_addr = 32'h9000_0000;
    tick();
    i_fill_req = 1'b0; i_wb_req = 1'b0;
    chk("busy_no_second_req", o_read_req, 1'b0);
    for (int k = 0; k < LW; k++) begin
      i_axi_handshake = 1'b1; i_read_data = 64'h500 + 64'(k);
      tick();
    end
    i_axi_handshake = 1'b0; i_axi_done = 1'b1;
    tick();
    i_axi_done = 1'b0;
    chk("busy_done", o_done, 1'b1);
    tick(); tick(); tick();
    chk("busy_idle", o_busy, 1'b0);
    chk("busy_rd_count", rd_pulses - rd0, 1);
    chk("busy_wr_count", wr_pulses - wr0, 0);
    chk("busy_line", o_fill_line, mk_line(64'h500));
    chk("never_both_req", both_high, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
